mc_ctrl_unit: RTL and testbench



---
 rtl/mc_ctrl_unit_pkg.sv | 56 +++++
 rtl/mc_ctrl_unit_if.sv | 44 ++++
 rtl/rv32_decoder.sv | 114 +++++++++++
 rtl/mc_ctrl_unit.sv | 144 ++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_unit_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32I control unit.
// Holds the FSM state enum, instruction classes, opcodes and datapath select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MDWAIT, S_MEM, S_WB, S_TRAP} state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_STORE, C_BRANCH, C_MD
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_IDLE = 4'd11;

    localparam logic [1:0] WB_PC4  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_LD   = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

    localparam logic [2:0] LD_NONE = 3'd5;
    localparam logic [1:0] ST_NONE = 2'd3;

    // alt selects SUB/SRA; callers must clear it where funct7[5] has no meaning
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_unit_if.sv
// mc_ctrl_unit_if: memory handshakes and datapath controls of the multicycle control unit.
interface mc_ctrl_unit_if;
    logic [31:0] i_instruction;
    logic        i_br_less;
    logic        i_br_equal;
    logic        i_imem_ack;
    logic        i_dmem_ack;
    logic        i_md_done;
    logic        o_imem_req;
    logic        o_dmem_req;
    logic        o_ir_wren;
    logic        o_pc_wren;
    logic        o_rd_wren;
    logic        o_mem_wren;
    logic        o_opa_sel;
    logic        o_opb_sel;
    logic        o_pc_sel;
    logic        o_br_uns;
    logic [1:0]  o_wb_sel;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_ld_rewrite;
    logic [1:0]  o_st_rewrite;
    logic        o_md_start;
    logic [2:0]  o_md_op;
    logic        o_insn_vld;
    logic        o_illegal;
    logic        o_timeout;

    modport master (
        input  i_instruction, i_br_less, i_br_equal, i_imem_ack, i_dmem_ack, i_md_done,
        output o_imem_req, o_dmem_req, o_ir_wren, o_pc_wren, o_rd_wren, o_mem_wren,
               o_opa_sel, o_opb_sel, o_pc_sel, o_br_uns, o_wb_sel, o_alu_op,
               o_ld_rewrite, o_st_rewrite, o_md_start, o_md_op, o_insn_vld,
               o_illegal, o_timeout
    );

    modport slave (
        output i_instruction, i_br_less, i_br_equal, i_imem_ack, i_dmem_ack, i_md_done,
        input  o_imem_req, o_dmem_req, o_ir_wren, o_pc_wren, o_rd_wren, o_mem_wren,
               o_opa_sel, o_opb_sel, o_pc_sel, o_br_uns, o_wb_sel, o_alu_op,
               o_ld_rewrite, o_st_rewrite, o_md_start, o_md_op, o_insn_vld,
               o_illegal, o_timeout
    );
endinterface

// File: rtl/rv32_decoder.sv
// rv32_decoder: combinational RV32I(+M) decode into class, ALU op, selects and rewrite codes.
module rv32_decoder
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] insn,
    input  logic        less,
    input  logic        equal,
    output iclass_t     cls,
    output logic [3:0]  alu_op,
    output logic        opa_sel,
    output logic        opb_sel,
    output logic        br_uns,
    output logic        br_taken,
    output logic        jump,
    output logic [1:0]  wb_sel,
    output logic [2:0]  ld_rw,
    output logic [1:0]  st_rw,
    output logic        illegal
);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       alt;
    logic       base;
    logic       unused_fields;

    assign opc           = insn[6:0];
    assign f3            = insn[14:12];
    assign f7            = insn[31:25];
    assign alt           = f7 == 7'b0100000;
    assign base          = f7 == 7'b0000000;
    assign unused_fields = ^{insn[24:15], insn[11:7]};

    assign br_uns   = cls == C_BRANCH && f3[1];
    assign br_taken = f3[2] ? (f3[0] ? (!less || equal) : less) : (equal ^ f3[0]);
    assign jump     = cls == C_JAL || cls == C_JALR;

    always_comb begin
        cls     = C_R;
        alu_op  = ALU_IDLE;
        opa_sel = 1'b0;
        opb_sel = 1'b0;
        wb_sel  = WB_ALU;
        ld_rw   = LD_NONE;
        st_rw   = ST_NONE;
        illegal = 1'b0;
        case (opc)
            OP_R: begin
                cls     = f7 == 7'b0000001 ? C_MD : C_R;
                alu_op  = f7 == 7'b0000001 ? ALU_IDLE : alu_of(f3, alt);
                illegal = f7 == 7'b0000001 ? !ENABLE_M
                                           : !(base || (alt && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_I: begin
                cls     = C_I;
                opb_sel = 1'b1;
                alu_op  = alu_of(f3, alt && f3 == 3'b101);
                illegal = f3 == 3'b001 ? !base : f3 == 3'b101 ? !(base || alt) : 1'b0;
            end
            OP_LUI: begin
                cls     = C_LUI;
                opb_sel = 1'b1;
                alu_op  = ALU_LUI;
            end
            OP_AUIPC: begin
                cls     = C_AUIPC;
                opa_sel = 1'b1;
                opb_sel = 1'b1;
                alu_op  = ALU_ADD;
            end
            OP_JAL: begin
                cls     = C_JAL;
                opa_sel = 1'b1;
                opb_sel = 1'b1;
                alu_op  = ALU_ADD;
                wb_sel  = WB_PC4;
            end
            OP_JALR: begin
                cls     = C_JALR;
                opb_sel = 1'b1;
                alu_op  = ALU_ADD;
                wb_sel  = WB_PC4;
                illegal = f3 != 3'b000;
            end
            OP_LOAD: begin
                cls     = C_LOAD;
                opb_sel = 1'b1;
                alu_op  = ALU_ADD;
                wb_sel  = WB_LD;
                ld_rw   = f3[2] ? 3'(f3[1:0]) + 3'd3 : f3;
                illegal = f3[1:0] == 2'b11 || (f3[2] && f3[1]);
            end
            OP_STORE: begin
                cls     = C_STORE;
                opb_sel = 1'b1;
                alu_op  = ALU_ADD;
                wb_sel  = WB_NONE;
                st_rw   = f3[1:0];
                illegal = f3[2] || f3[1:0] == 2'b11;
            end
            OP_BRANCH: begin
                cls     = C_BRANCH;
                opa_sel = 1'b1;
                opb_sel = 1'b1;
                alu_op  = ALU_ADD;
                wb_sel  = WB_NONE;
                illegal = f3[2:1] == 2'b01;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle RV32I control FSM with memory/mul-div handshakes and timeout trap.
module mc_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M    = 1'b0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mc_ctrl_unit_if.master bus
);
    localparam int             CW      = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYC - 1);

    state_t        state;
    state_t        next;
    iclass_t       cls;
    logic          run;
    logic [CW-1:0] cnt;
    logic          ill_q;
    logic          to_q;
    logic          wait_st;
    logic          got;
    logic          expire;
    logic [3:0]    dec_alu;
    logic          dec_opa;
    logic          dec_opb;
    logic          dec_uns;
    logic          taken;
    logic          jump;
    logic [1:0]    dec_wb;
    logic [2:0]    dec_ld;
    logic [1:0]    dec_st;
    logic          dec_ill;

    rv32_decoder #(.ENABLE_M(ENABLE_M)) u_dec (
        .insn     (bus.i_instruction),
        .less     (bus.i_br_less),
        .equal    (bus.i_br_equal),
        .cls      (cls),
        .alu_op   (dec_alu),
        .opa_sel  (dec_opa),
        .opb_sel  (dec_opb),
        .br_uns   (dec_uns),
        .br_taken (taken),
        .jump     (jump),
        .wb_sel   (dec_wb),
        .ld_rw    (dec_ld),
        .st_rw    (dec_st),
        .illegal  (dec_ill)
    );

    // run holds the FSM idle for the first cycle after reset so requests start one cycle later
    assign wait_st = run && (state == S_FETCH || state == S_MEM || state == S_MDWAIT);
    assign got     = state == S_FETCH ? bus.i_imem_ack : state == S_MEM ? bus.i_dmem_ack : bus.i_md_done;
    assign expire  = TIMEOUT_CYC != 0 && wait_st && !got && cnt == CNT_MAX;

    assign bus.o_illegal = ill_q;
    assign bus.o_timeout = to_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_FETCH;
            run   <= 1'b0;
            cnt   <= '0;
            ill_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= next;
            cnt   <= (next != state || !wait_st) ? '0 : cnt + 1'b1;
            ill_q <= ill_q || (state == S_DECODE && next == S_TRAP);
            to_q  <= to_q || expire;
        end
    end

    always_comb begin
        next             = state;
        bus.o_imem_req   = 1'b0;
        bus.o_dmem_req   = 1'b0;
        bus.o_ir_wren    = 1'b0;
        bus.o_pc_wren    = 1'b0;
        bus.o_rd_wren    = 1'b0;
        bus.o_mem_wren   = 1'b0;
        bus.o_opa_sel    = 1'b0;
        bus.o_opb_sel    = 1'b0;
        bus.o_pc_sel     = 1'b0;
        bus.o_br_uns     = 1'b0;
        bus.o_wb_sel     = WB_ALU;
        bus.o_alu_op     = ALU_IDLE;
        bus.o_ld_rewrite = LD_NONE;
        bus.o_st_rewrite = ST_NONE;
        bus.o_md_start   = 1'b0;
        bus.o_md_op      = 3'd0;
        bus.o_insn_vld   = 1'b0;
        if (run) begin
            case (state)
                S_FETCH: begin
                    bus.o_imem_req = 1'b1;
                    bus.o_ir_wren  = bus.i_imem_ack;
                    next           = bus.i_imem_ack ? S_DECODE : S_FETCH;
                end
                S_DECODE: next = dec_ill ? S_TRAP : S_EXEC;
                S_EXEC: begin
                    bus.o_opa_sel  = dec_opa;
                    bus.o_opb_sel  = dec_opb;
                    bus.o_alu_op   = dec_alu;
                    bus.o_br_uns   = dec_uns;
                    bus.o_pc_sel   = cls == C_BRANCH && taken;
                    bus.o_pc_wren  = cls == C_BRANCH;
                    bus.o_insn_vld = cls == C_BRANCH;
                    bus.o_md_start = cls == C_MD;
                    bus.o_md_op    = cls == C_MD ? bus.i_instruction[14:12] : 3'd0;
                    next = cls == C_BRANCH ? S_FETCH
                         : (cls == C_LOAD || cls == C_STORE) ? S_MEM
                         : cls == C_MD ? S_MDWAIT : S_WB;
                end
                S_MDWAIT: begin
                    bus.o_md_op = bus.i_instruction[14:12];
                    next        = bus.i_md_done ? S_WB : S_MDWAIT;
                end
                S_MEM: begin
                    bus.o_dmem_req   = 1'b1;
                    bus.o_mem_wren   = cls == C_STORE;
                    bus.o_ld_rewrite = dec_ld;
                    bus.o_st_rewrite = dec_st;
                    bus.o_pc_wren    = cls == C_STORE && bus.i_dmem_ack;
                    bus.o_insn_vld   = cls == C_STORE && bus.i_dmem_ack;
                    next = !bus.i_dmem_ack ? S_MEM : cls == C_STORE ? S_FETCH : S_WB;
                end
                S_WB: begin
                    bus.o_rd_wren  = 1'b1;
                    bus.o_pc_wren  = 1'b1;
                    bus.o_insn_vld = 1'b1;
                    bus.o_wb_sel   = dec_wb;
                    bus.o_pc_sel   = jump;
                    next           = S_FETCH;
                end
                default: next = S_TRAP;
            endcase
            if (expire) next = S_TRAP;
        end
    end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: directed checks of mc_ctrl_unit with and without the M extension.
module tb_mc_ctrl_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vld0   = 0;

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] BLTU = 32'h0020E463;
    localparam logic [31:0] SW   = 32'h0020A023;
    localparam logic [31:0] MUL  = 32'h022081B3;

    mc_ctrl_unit_if bus0();
    mc_ctrl_unit_if bus1();

    mc_ctrl_unit #(.ENABLE_M(1'b0), .TIMEOUT_CYC(16)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    mc_ctrl_unit #(.ENABLE_M(1'b1), .TIMEOUT_CYC(16)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

    assign bus1.i_instruction = bus0.i_instruction;
    assign bus1.i_br_less     = bus0.i_br_less;
    assign bus1.i_br_equal    = bus0.i_br_equal;
    assign bus1.i_imem_ack    = bus0.i_imem_ack;
    assign bus1.i_dmem_ack    = bus0.i_dmem_ack;
    assign bus1.i_md_done     = bus0.i_md_done;

    always #5 clk = ~clk;

    always @(posedge clk) if (bus0.o_insn_vld) vld0 <= vld0 + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic ia, input logic da, input logic md);
        @(negedge clk);
        bus0.i_imem_ack = ia;
        bus0.i_dmem_ack = da;
        bus0.i_md_done  = md;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus0.i_instruction = ADD;
        bus0.i_br_less     = 1'b0;
        bus0.i_br_equal    = 1'b0;
        bus0.i_imem_ack    = 1'b0;
        bus0.i_dmem_ack    = 1'b0;
        bus0.i_md_done     = 1'b0;
        do_reset();
        check("rst_imem_req", bus0.o_imem_req, 0);
        check("rst_alu_op", bus0.o_alu_op, 11);
        check("rst_wb_sel", bus0.o_wb_sel, 1);
        check("rst_ld_rw", bus0.o_ld_rewrite, 5);
        check("rst_st_rw", bus0.o_st_rewrite, 3);
        check("rst_flags", {bus0.o_illegal, bus0.o_timeout, bus0.o_insn_vld}, 0);
        // ADD, zero-wait
        step(1, 0, 0);
        check("add_fetch_req", bus0.o_imem_req, 1);
        check("add_ir_wren", bus0.o_ir_wren, 1);
        step(0, 0, 0);
        check("add_decode_req", bus0.o_imem_req, 0);
        step(0, 0, 0);
        check("add_exec_alu", bus0.o_alu_op, 0);
        check("add_exec_rd", bus0.o_rd_wren, 0);
        step(0, 0, 0);
        check("add_wb_rd", bus0.o_rd_wren, 1);
        check("add_wb_sel", bus0.o_wb_sel, 1);
        check("add_wb_pc", {bus0.o_pc_wren, bus0.o_pc_sel}, 2'b10);
        // LW with 3 wait cycles
        step(1, 0, 0);
        bus0.i_instruction = LW;
        check("add_vld_once", vld0, 1);
        check("lw_fetch_req", bus0.o_imem_req, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        check("lw_exec", {bus0.o_alu_op, bus0.o_opb_sel}, {4'd0, 1'b1});
        step(0, 0, 0);
        check("lw_mem_req", {bus0.o_dmem_req, bus0.o_mem_wren}, 2'b10);
        check("lw_ld_rw", bus0.o_ld_rewrite, 2);
        step(0, 0, 0);
        step(0, 0, 0);
        check("lw_mem_wait3", bus0.o_dmem_req, 1);
        step(0, 1, 0);
        check("lw_mem_ack", {bus0.o_dmem_req, bus0.o_rd_wren}, 2'b10);
        step(0, 0, 0);
        check("lw_wb_sel", bus0.o_wb_sel, 2);
        check("lw_wb", {bus0.o_rd_wren, bus0.o_dmem_req}, 2'b10);
        check("lw_wb_ld_idle", bus0.o_ld_rewrite, 5);
        // BEQ taken then not taken
        step(1, 0, 0);
        bus0.i_instruction = BEQ;
        bus0.i_br_equal    = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        check("beq_t_pc_sel", bus0.o_pc_sel, 1);
        check("beq_t_strobes", {bus0.o_pc_wren, bus0.o_insn_vld, bus0.o_rd_wren}, 3'b110);
        check("beq_t_opa", {bus0.o_opa_sel, bus0.o_br_uns}, 2'b10);
        step(1, 0, 0);
        check("beq_next_fetch", bus0.o_imem_req, 1);
        bus0.i_br_equal = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        check("beq_nt_pc_sel", bus0.o_pc_sel, 0);
        check("beq_nt_strobes", {bus0.o_pc_wren, bus0.o_rd_wren}, 2'b10);
        // BLTU taken on less
        step(1, 0, 0);
        bus0.i_instruction = BLTU;
        bus0.i_br_less     = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        check("bltu_taken", {bus0.o_pc_sel, bus0.o_br_uns}, 2'b11);
        bus0.i_br_less = 1'b0;
        // SW zero-wait
        step(1, 0, 0);
        bus0.i_instruction = SW;
        step(0, 0, 0);
        step(0, 0, 0);
        check("sw_exec_opb", bus0.o_opb_sel, 1);
        step(0, 1, 0);
        check("sw_mem", {bus0.o_dmem_req, bus0.o_mem_wren, bus0.o_rd_wren}, 3'b110);
        check("sw_st_rw", bus0.o_st_rewrite, 2);
        check("sw_retire", {bus0.o_pc_wren, bus0.o_insn_vld}, 2'b11);
        // MUL: illegal on dut0, sequenced on dut1
        step(1, 0, 0);
        bus0.i_instruction = MUL;
        check("sw_next_fetch", {bus0.o_imem_req, bus0.o_mem_wren}, 2'b10);
        check("vld_count6", vld0, 6);
        step(0, 0, 0);
        step(0, 0, 0);
        check("mul_m_start", {bus1.o_md_start, bus1.o_md_op}, {1'b1, 3'd0});
        check("mul_nom_illegal", bus0.o_illegal, 1);
        check("mul_nom_req", bus0.o_imem_req, 0);
        check("mul_m_not_illegal", bus1.o_illegal, 0);
        step(0, 0, 0);
        check("mul_m_wait", {bus1.o_md_start, bus1.o_rd_wren}, 2'b00);
        step(0, 0, 1);
        check("mul_m_done_cyc", bus1.o_rd_wren, 0);
        step(1, 0, 0);
        check("mul_m_wb", {bus1.o_rd_wren, bus1.o_insn_vld, bus1.o_wb_sel}, {2'b11, 2'b01});
        check("trap_ignores_ack", {bus0.o_imem_req, bus0.o_ir_wren, bus0.o_illegal}, 3'b001);
        // Fetch timeout
        bus0.i_instruction = ADD;
        do_reset();
        repeat (15) step(0, 0, 0);
        step(0, 0, 0);
        check("to_cyc16", {bus0.o_imem_req, bus0.o_timeout}, 2'b10);
        step(0, 0, 0);
        check("to_trap", {bus0.o_imem_req, bus0.o_timeout}, 2'b01);
        check("to_trap_m", bus1.o_timeout, 1);
        do_reset();
        check("to_cleared", bus0.o_timeout, 0);
        repeat (15) step(0, 0, 0);
        step(1, 0, 0);
        check("ack16_irw", bus0.o_ir_wren, 1);
        step(0, 0, 0);
        check("ack16_no_to", {bus0.o_timeout, bus0.o_imem_req}, 2'b00);
        step(0, 0, 0);
        step(0, 0, 0);
        check("ack16_wb", bus0.o_rd_wren, 1);
        // Reset during MEM wait
        step(1, 0, 0);
        bus0.i_instruction = LW;
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("rmem_req", bus0.o_dmem_req, 1);
        rst_n = 1'b0;
        step(0, 1, 0);
        check("rmem_abort", {bus0.o_dmem_req, bus0.o_imem_req, bus0.o_rd_wren}, 3'b000);
        rst_n = 1'b1;
        step(0, 0, 0);
        check("rmem_refetch", {bus0.o_imem_req, bus0.o_dmem_req}, 2'b10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
